// File: rtl/icache_axi_pkg.sv
// Shared AXI encodings, refill FSM states and elaboration helpers for the
// instruction-cache refill master.
package icache_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_ADDR = 2'd1,
    RF_DATA = 2'd2,
    RF_DONE = 2'd3
  } refill_state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Cache-line assembly buffer: one indexed word write per cycle, whole line
// visible on a flat port, cleared by the shared synchronous reset.
module refill_line_buf
  import icache_axi_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = clog2(LINE_WORDS)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             we_i,
  input  logic [IDX_W-1:0]                 widx_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_o
);

  logic [DATA_WIDTH-1:0] words_q [LINE_WORDS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LINE_WORDS; i++) words_q[i] <= '0;
    end else if (we_i) begin
      words_q[widx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign line_o[g*DATA_WIDTH +: DATA_WIDTH] = words_q[g];
  end

endmodule

// File: rtl/icache_refill_axi.sv
// AXI4 read master turning I-cache misses into single line-sized bursts.
// Define ICACHE_REFILL_CWF_EN for critical-word-first WRAP bursts.
module icache_refill_axi
  import icache_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             rst,
  input  logic                             miss_valid,
  output logic                             miss_ready,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  output logic                             refill_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] refill_data,
  output logic                             refill_err,
  output logic                             crit_valid,
  output logic [DATA_WIDTH-1:0]            crit_data,
  output logic [ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [7:0]                       M_AXI_ARLEN,
  output logic [2:0]                       M_AXI_ARSIZE,
  output logic [1:0]                       M_AXI_ARBURST,
  output logic                             M_AXI_ARVALID,
  input  logic                             M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                       M_AXI_RRESP,
  input  logic                             M_AXI_RLAST,
  input  logic                             M_AXI_RVALID,
  output logic                             M_AXI_RREADY
);

  localparam int IDX_W = clog2(LINE_WORDS);
  localparam int OFF   = IDX_W + 2;
  localparam int CNT_W = IDX_W + 1;

  refill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;

  logic                    r_hs;
  logic                    last_beat;
  logic [IDX_W-1:0]        start_word;
  logic [IDX_W-1:0]        widx;

  assign miss_ready    = (state_q == RF_IDLE) && !rst;
  assign M_AXI_ARVALID = (state_q == RF_ADDR);
  assign M_AXI_RREADY  = (state_q == RF_DATA);
  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign refill_valid  = (state_q == RF_DONE);
  assign refill_err    = refill_valid && err_q;

  assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
  assign last_beat = (beat_cnt_q == CNT_W'(LINE_WORDS - 1));

`ifdef ICACHE_REFILL_CWF_EN
  // The slave wraps from the missing word, so beat k lands at start_word + k.
  assign M_AXI_ARADDR  = addr_q & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign M_AXI_ARBURST = AXI_BURST_WRAP;
  assign start_word    = addr_q[OFF-1:2];
  assign crit_valid    = r_hs && (beat_cnt_q == '0);
  assign crit_data     = crit_valid ? M_AXI_RDATA : '0;
`else
  assign M_AXI_ARADDR  = addr_q & {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign start_word    = '0;
  assign crit_valid    = 1'b0;
  assign crit_data     = '0;
`endif

  assign widx = start_word + beat_cnt_q[IDX_W-1:0];

  // A misplaced RLAST (early or missing) poisons the line but always ends the burst.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      RF_IDLE: begin
        if (miss_valid && miss_ready) begin
          addr_d     = miss_addr;
          beat_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = RF_ADDR;
        end
      end
      RF_ADDR: begin
        if (M_AXI_ARREADY) state_d = RF_DATA;
      end
      RF_DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (M_AXI_RRESP != AXI_RESP_OKAY) err_d = 1'b1;
          if (last_beat) begin
            if (!M_AXI_RLAST) err_d = 1'b1;
            state_d = RF_DONE;
          end else if (M_AXI_RLAST) begin
            err_d   = 1'b1;
            state_d = RF_DONE;
          end
        end
      end
      RF_DONE: state_d = RF_IDLE;
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      state_q    <= RF_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  refill_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buf (
    .clk_i   (S_AXI_ACLK),
    .rst_i   (rst),
    .we_i    (r_hs),
    .widx_i  (widx),
    .wdata_i (M_AXI_RDATA),
    .line_o  (refill_data)
  );

endmodule
